// File: rtl/attitude_quantizer_if.sv
// Sample/attitude bus between the attitude producer and attitude_quantizer.
//   i_Roll, i_Pitch   : signed roll/pitch sample pair (two's complement)
//   i_Sample_Valid    : sample pair valid
//   o_Sample_Ready    : quantizer ready to accept a sample
//   o_Attitude        : {isZero(pitch), isZero(roll), sgn(pitch), sgn(roll)}
//   o_Update          : one-cycle pulse when o_Attitude changes
//   o_Stale           : no valid smoothed data available
// master drives samples, slave is the quantizer.
interface attitude_quantizer_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] i_Roll;
    logic signed [DATA_W-1:0] i_Pitch;
    logic                     i_Sample_Valid;
    logic                     o_Sample_Ready;
    logic [3:0]               o_Attitude;
    logic                     o_Update;
    logic                     o_Stale;

    modport master (
        output i_Roll, i_Pitch, i_Sample_Valid,
        input  o_Sample_Ready, o_Attitude, o_Update, o_Stale
    );

    modport slave (
        input  i_Roll, i_Pitch, i_Sample_Valid,
        output o_Sample_Ready, o_Attitude, o_Update, o_Stale
    );
endinterface

// File: rtl/attitude_quantizer.sv
// Attitude quantizer: smooths roll/pitch samples with a moving average, applies a
// per-axis zero deadband with hysteresis, debounces the 4-bit attitude code and
// forces the "level" code when the sample stream stalls.
// Ports:
//   i_Clk   : system clock, rising edge
//   i_Rst_n : asynchronous active-low reset
//   bus     : attitude_quantizer_if slave (samples in, attitude/update/stale out)
module attitude_quantizer #(
    parameter int DATA_W         = 16,
    parameter int AVG_LOG2       = 2,
    parameter int ZERO_ENTER     = 64,
    parameter int ZERO_EXIT      = 128,
    parameter int STABLE_SAMPLES = 3,
    parameter int TIMEOUT_CYC    = 1000000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    attitude_quantizer_if.slave  bus
);
    localparam int NUM     = 1 << AVG_LOG2;
    localparam int SUM_W   = DATA_W + AVG_LOG2;
    localparam int WARM_W  = AVG_LOG2 + 1;
    localparam int CNT_W   = $clog2(STABLE_SAMPLES + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DATA_W-1:0]  MAG_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  MAG_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  ENTER_V   = DATA_W'(ZERO_ENTER);
    localparam logic [DATA_W-1:0]  EXIT_V    = DATA_W'(ZERO_EXIT);
    localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'(NUM - 1);
    localparam logic [CNT_W-1:0]   STABLE_V  = CNT_W'(STABLE_SAMPLES);
    localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT_CYC);
    localparam logic [3:0]         LEVEL     = 4'b1100;

    typedef enum logic [1:0] {
        StWarmup,
        StTrack,
        StStale
    } state_e;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  roll_win_q  [NUM];
    logic signed [DATA_W-1:0]  roll_win_d  [NUM];
    logic signed [DATA_W-1:0]  pitch_win_q [NUM];
    logic signed [DATA_W-1:0]  pitch_win_d [NUM];
    logic signed [SUM_W-1:0]   roll_sum_q, roll_sum_d;
    logic signed [SUM_W-1:0]   pitch_sum_q, pitch_sum_d;
    logic [WARM_W-1:0]         warm_cnt_q, warm_cnt_d;
    logic [TIMER_W-1:0]        idle_q, idle_d;
    logic                      strobe_q, strobe_d;
    logic                      zero_roll_q, zero_roll_d;
    logic                      zero_pitch_q, zero_pitch_d;
    logic [3:0]                pend_q, pend_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                att_q, att_d;
    logic                      upd_q, upd_d;
    logic                      stale_q, stale_d;
    logic                      ready_q, ready_d;

    logic                      accept;
    logic [DATA_W-1:0]         roll_avg, pitch_avg;
    logic [DATA_W-1:0]         roll_mag, pitch_mag;
    logic                      zero_roll_new, zero_pitch_new;
    logic [3:0]                cand;
    logic [CNT_W-1:0]          cnt_next;

    // |a| with the most negative value saturating to the largest positive value.
    function automatic logic [DATA_W-1:0] sat_mag(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (a == MAG_MIN) begin
            r = MAG_MAX;
        end else if (a[DATA_W-1]) begin
            r = -a;
        end else begin
            r = a;
        end
        return r;
    endfunction

    function automatic logic is_pos(input logic [DATA_W-1:0] a);
        return !a[DATA_W-1] && (a != '0);
    endfunction

    // Deadband with hysteresis: entering zero uses the lower threshold.
    function automatic logic next_zero(input logic z, input logic [DATA_W-1:0] mag);
        return z ? (mag < EXIT_V) : (mag < ENTER_V);
    endfunction

    assign accept = bus.i_Sample_Valid && ready_q;

    // Arithmetic shift right by AVG_LOG2 then truncation to DATA_W is exactly this
    // slice; the average of DATA_W-bit samples always fits in DATA_W bits.
    assign roll_avg  = roll_sum_q[SUM_W-1:AVG_LOG2];
    assign pitch_avg = pitch_sum_q[SUM_W-1:AVG_LOG2];
    assign roll_mag  = sat_mag(roll_avg);
    assign pitch_mag = sat_mag(pitch_avg);

    assign zero_roll_new  = next_zero(zero_roll_q, roll_mag);
    assign zero_pitch_new = next_zero(zero_pitch_q, pitch_mag);
    assign cand = {zero_pitch_new, zero_roll_new,
                   is_pos(pitch_avg) && !zero_pitch_new,
                   is_pos(roll_avg) && !zero_roll_new};

    assign cnt_next = (pend_vld_q && (cand == pend_q)) ? cnt_q + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        roll_win_d   = roll_win_q;
        pitch_win_d  = pitch_win_q;
        roll_sum_d   = roll_sum_q;
        pitch_sum_d  = pitch_sum_q;
        warm_cnt_d   = warm_cnt_q;
        idle_d       = idle_q;
        strobe_d     = 1'b0;
        zero_roll_d  = zero_roll_q;
        zero_pitch_d = zero_pitch_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        cnt_d        = cnt_q;
        att_d        = att_q;
        upd_d        = 1'b0;
        stale_d      = stale_q;
        ready_d      = 1'b1;

        // Evaluation uses the sums as they stood after the previous acceptance.
        if (strobe_q) begin
            zero_roll_d  = zero_roll_new;
            zero_pitch_d = zero_pitch_new;
            if (cand == att_q) begin
                pend_vld_d = 1'b0;
                cnt_d      = '0;
            end else begin
                pend_d     = cand;
                pend_vld_d = 1'b1;
                cnt_d      = cnt_next;
                if (cnt_next == STABLE_V) begin
                    att_d      = cand;
                    upd_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                end
            end
        end

        if (accept) begin
            roll_sum_d  = roll_sum_q + SUM_W'(bus.i_Roll) - SUM_W'(roll_win_q[NUM-1]);
            pitch_sum_d = pitch_sum_q + SUM_W'(bus.i_Pitch) - SUM_W'(pitch_win_q[NUM-1]);
            for (int i = NUM - 1; i > 0; i--) begin
                roll_win_d[i]  = roll_win_q[i-1];
                pitch_win_d[i] = pitch_win_q[i-1];
            end
            roll_win_d[0]  = bus.i_Roll;
            pitch_win_d[0] = bus.i_Pitch;
        end

        unique case (state_q)
            StWarmup, StStale: begin
                // STALE already holds cleared history, so its first sample is
                // simply warmup sample 1.
                if (accept) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d    = StTrack;
                        stale_d    = 1'b0;
                        strobe_d   = 1'b1;
                        warm_cnt_d = '0;
                        idle_d     = '0;
                    end else begin
                        state_d    = StWarmup;
                        warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    end
                end
            end
            StTrack: begin
                if (accept) begin
                    idle_d   = '0;
                    strobe_d = 1'b1;
                end else if (idle_q + TIMER_W'(1) == TIMEOUT_V) begin
                    state_d      = StStale;
                    stale_d      = 1'b1;
                    att_d        = LEVEL;
                    upd_d        = (att_q != LEVEL);
                    roll_win_d   = '{default: '0};
                    pitch_win_d  = '{default: '0};
                    roll_sum_d   = '0;
                    pitch_sum_d  = '0;
                    pend_vld_d   = 1'b0;
                    pend_d       = '0;
                    cnt_d        = '0;
                    zero_roll_d  = 1'b1;
                    zero_pitch_d = 1'b1;
                    warm_cnt_d   = '0;
                    idle_d       = '0;
                end else begin
                    idle_d = idle_q + TIMER_W'(1);
                end
            end
            default: state_d = StWarmup;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= StWarmup;
            roll_win_q   <= '{default: '0};
            pitch_win_q  <= '{default: '0};
            roll_sum_q   <= '0;
            pitch_sum_q  <= '0;
            warm_cnt_q   <= '0;
            idle_q       <= '0;
            strobe_q     <= 1'b0;
            zero_roll_q  <= 1'b1;
            zero_pitch_q <= 1'b1;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            cnt_q        <= '0;
            att_q        <= LEVEL;
            upd_q        <= 1'b0;
            stale_q      <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            roll_win_q   <= roll_win_d;
            pitch_win_q  <= pitch_win_d;
            roll_sum_q   <= roll_sum_d;
            pitch_sum_q  <= pitch_sum_d;
            warm_cnt_q   <= warm_cnt_d;
            idle_q       <= idle_d;
            strobe_q     <= strobe_d;
            zero_roll_q  <= zero_roll_d;
            zero_pitch_q <= zero_pitch_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            cnt_q        <= cnt_d;
            att_q        <= att_d;
            upd_q        <= upd_d;
            stale_q      <= stale_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.o_Attitude     = att_q;
    assign bus.o_Update       = upd_q;
    assign bus.o_Stale        = stale_q;
    assign bus.o_Sample_Ready = ready_q;
endmodule

// File: tb/tb_attitude_quantizer.sv
// Bench for attitude_quantizer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the averaging/deadband/
// debounce rules and against fixed expected codes.
module tb_attitude_quantizer;
    localparam int DATA_W   = 16;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 4;
    localparam int ENTER    = 64;
    localparam int EXIT     = 128;
    localparam int STABLE   = 3;
    localparam int TIMEOUT  = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    attitude_quantizer_if #(.DATA_W(DATA_W)) bus ();

    attitude_quantizer #(
        .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .ZERO_ENTER(ENTER), .ZERO_EXIT(EXIT),
        .STABLE_SAMPLES(STABLE), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_r[$];
    int         m_p[$];
    bit         m_ready, m_track, m_eval, m_zr, m_zp, m_pend_v, m_upd, m_stale;
    logic [3:0] m_att, m_pend;
    int         m_cnt, m_warm, m_idle;

    task automatic model_clear_history();
        m_r.delete();
        m_p.delete();
        repeat (N) begin
            m_r.push_back(0);
            m_p.push_back(0);
        end
        m_zr = 1; m_zp = 1; m_pend_v = 0; m_cnt = 0; m_warm = 0; m_idle = 0; m_eval = 0;
    endtask

    task automatic model_reset();
        model_clear_history();
        m_ready = 0; m_track = 0; m_upd = 0; m_stale = 1; m_att = 4'b1100; m_pend = 4'b0;
    endtask

    // Mean of the window rounded toward minus infinity.
    function automatic int floor_mean(input int q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += q[i];
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int sat_abs(input int a);
        if (a == -(1 << (DATA_W - 1))) return (1 << (DATA_W - 1)) - 1;
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_edge(input bit v, input int r, input int p);
        bit         acc;
        int         ar, ap;
        logic [3:0] cand;
        acc   = v && m_ready;
        m_upd = 0;
        if (m_eval) begin
            ar = floor_mean(m_r);
            ap = floor_mean(m_p);
            m_zr = m_zr ? (sat_abs(ar) < EXIT) : (sat_abs(ar) < ENTER);
            m_zp = m_zp ? (sat_abs(ap) < EXIT) : (sat_abs(ap) < ENTER);
            cand = {m_zp, m_zr, (ap > 0) && !m_zp, (ar > 0) && !m_zr};
            if (cand == m_att) begin
                m_pend_v = 0;
                m_cnt    = 0;
            end else begin
                m_cnt    = (m_pend_v && cand == m_pend) ? m_cnt + 1 : 1;
                m_pend   = cand;
                m_pend_v = 1;
                if (m_cnt == STABLE) begin
                    m_att = cand; m_upd = 1; m_cnt = 0; m_pend_v = 0;
                end
            end
        end
        m_eval = 0;
        if (acc) begin
            m_r.push_front(r); void'(m_r.pop_back());
            m_p.push_front(p); void'(m_p.pop_back());
        end
        if (!m_track) begin
            if (acc) begin
                m_warm++;
                if (m_warm == N) begin
                    m_track = 1; m_stale = 0; m_eval = 1; m_warm = 0; m_idle = 0;
                end
            end
        end else if (acc) begin
            m_idle = 0;
            m_eval = 1;
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_track = 0; m_stale = 1;
                if (m_att != 4'b1100) m_upd = 1;
                m_att = 4'b1100;
                model_clear_history();
            end
        end
        m_ready = 1;
    endtask

    // ---------------- stimulus ----------------
    task automatic cycle(input bit v, input int r, input int p);
        bus.i_Sample_Valid = v;
        bus.i_Roll         = DATA_W'(r);
        bus.i_Pitch        = DATA_W'(p);
        @(posedge clk);
        model_edge(v, r, p);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_Sample_Valid = 1'b0;
        bus.i_Roll = '0;
        bus.i_Pitch = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int pick_value();
        case ($urandom_range(0, 5))
            0: return int'($urandom_range(0, 400)) - 200;
            1: return int'($urandom_range(0, 4000)) - 2000;
            2: return -32768;
            3: return 32767;
            4: return int'($urandom_range(0, 300)) - 150;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready} !== 7'b1100_0_1_0)
            $display("FAIL reset_values got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready}, 7'b1100010);
        else n_pass++;
        cycle(0, 0, 0);
        n_checks++;
        if ({bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready} !== 7'b1100_0_1_1)
            $display("FAIL ready_after_reset got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready}, 7'b1100011);
        else n_pass++;
    endtask

    // Caller leaves the DUT freshly out of reset.
    task automatic test_warmup_commit();
        int         acc_n;
        bit         was_ready;
        logic [5:0] exp_v;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            was_ready = m_ready;
            cycle(1, 1000, -1000);
            if (was_ready) acc_n++;
            exp_v = {(acc_n >= 7) ? 4'b0001 : 4'b1100, acc_n == 7, acc_n < 4};
            n_checks++;
            if ({bus.o_Attitude, bus.o_Update, bus.o_Stale} !== exp_v)
                $display("FAIL warmup_commit acc=%0d got=%b expected=%b", acc_n,
                         {bus.o_Attitude, bus.o_Update, bus.o_Stale}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_hysteresis();
        int         levels[4];
        logic [3:0] exp_att[4];
        bit         exp_zero[4];
        levels   = '{100, 130, 100, 50};
        exp_att  = '{4'b1100, 4'b1001, 4'b1001, 4'b1100};
        exp_zero = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(1, 100, 0);
        for (int ph = 0; ph < 4; ph++) begin
            for (int s = 0; s < 8; s++) begin
                cycle(1, levels[ph], 0);
                n_checks++;
                if ({bus.o_Attitude, bus.o_Update, bus.o_Stale} !== {m_att, m_upd, m_stale})
                    $display("FAIL hyst_model phase=%0d got=%b expected=%b", ph,
                             {bus.o_Attitude, bus.o_Update, bus.o_Stale}, {m_att, m_upd, m_stale});
                else n_pass++;
            end
            n_checks++;
            if (bus.o_Attitude !== exp_att[ph] || dut.zero_roll_q !== exp_zero[ph])
                $display("FAIL hyst_phase%0d got att=%b zero=%b expected att=%b zero=%b", ph,
                         bus.o_Attitude, dut.zero_roll_q, exp_att[ph], exp_zero[ph]);
            else n_pass++;
        end
    endtask

    task automatic test_debounce_reject();
        int pattern[6];
        pattern = '{-5000, 1000, 9000, 1000, 1000, 1000};
        apply_reset();
        for (int i = 0; i < 12; i++) cycle(1, 1000, -1000);
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 6; k++) begin
                cycle(1, pattern[k], -1000);
                n_checks++;
                if ({bus.o_Attitude, bus.o_Update} !== 5'b0001_0 ||
                    {bus.o_Attitude, bus.o_Update} !== {m_att, m_upd})
                    $display("FAIL debounce_reject rep=%0d k=%0d got=%b expected=%b", rep, k,
                             {bus.o_Attitude, bus.o_Update}, 5'b00010);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1, -32768, 32767);
            n_checks++;
            if (bus.o_Attitude[0] !== 1'b0 ||
                {bus.o_Attitude, bus.o_Update, bus.o_Stale} !== {m_att, m_upd, m_stale})
                $display("FAIL saturation cyc=%0d got=%b expected=%b", i,
                         {bus.o_Attitude, bus.o_Update, bus.o_Stale}, {m_att, m_upd, m_stale});
            else n_pass++;
        end
        n_checks++;
        if (bus.o_Attitude !== 4'b0010)
            $display("FAIL saturation_code got=%b expected=%b", bus.o_Attitude, 4'b0010);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [5:0] exp_v;
        apply_reset();
        for (int i = 0; i < 12; i++) cycle(1, 1000, -1000);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            cycle(0, 0, 0);
            if (k < TIMEOUT)       exp_v = {4'b0001, 1'b0, 1'b0};
            else if (k == TIMEOUT) exp_v = {4'b1100, 1'b1, 1'b1};
            else                   exp_v = {4'b1100, 1'b0, 1'b1};
            n_checks++;
            if ({bus.o_Attitude, bus.o_Update, bus.o_Stale} !== exp_v)
                $display("FAIL timeout idle=%0d got=%b expected=%b", k,
                         {bus.o_Attitude, bus.o_Update, bus.o_Stale}, exp_v);
            else n_pass++;
        end
        // Recover, then accept exactly on the expiring cycle.
        for (int i = 0; i < 12; i++) cycle(1, 1000, -1000);
        n_checks++;
        if ({bus.o_Attitude, bus.o_Stale} !== 5'b0001_0)
            $display("FAIL timeout_recover got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Stale}, 5'b00010);
        else n_pass++;
        repeat (TIMEOUT - 1) cycle(0, 0, 0);
        cycle(1, 1000, -1000);
        n_checks++;
        if ({bus.o_Attitude, bus.o_Update, bus.o_Stale} !== 6'b0001_0_0)
            $display("FAIL timeout_accept_wins got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Update, bus.o_Stale}, 6'b000100);
        else n_pass++;
        repeat (TIMEOUT - 1) cycle(0, 0, 0);
        n_checks++;
        if ({bus.o_Attitude, bus.o_Stale} !== 5'b0001_0 ||
            {bus.o_Attitude, bus.o_Stale} !== {m_att, m_stale})
            $display("FAIL timeout_no_stale got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Stale}, 5'b00010);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) cycle(1, 1000, -1000);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready} !== 7'b1100_0_1_0)
            $display("FAIL async_reset_immediate got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready}, 7'b1100010);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready} !== 7'b1100_0_1_0)
            $display("FAIL async_reset_held got=%b expected=%b",
                     {bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready}, 7'b1100010);
        else n_pass++;
        rst_n = 1'b1;
        test_warmup_commit();
    endtask

    task automatic test_random();
        int idle_burst;
        bit v;
        idle_burst = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (idle_burst > 0) begin
                v = 0;
                idle_burst--;
            end else begin
                v = ($urandom_range(0, 99) < 85);
                if ($urandom_range(0, 79) == 0) idle_burst = TIMEOUT + 3;
            end
            cycle(v, pick_value(), pick_value());
            n_checks++;
            if ({bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready} !==
                {m_att, m_upd, m_stale, m_ready})
                $display("FAIL random_model cyc=%0d got=%b expected=%b", i,
                         {bus.o_Attitude, bus.o_Update, bus.o_Stale, bus.o_Sample_Ready},
                         {m_att, m_upd, m_stale, m_ready});
            else n_pass++;
        end
    endtask

    initial begin
        bus.i_Sample_Valid = 1'b0;
        bus.i_Roll         = '0;
        bus.i_Pitch        = '0;
        test_reset();
        apply_reset();
        test_warmup_commit();
        test_hysteresis();
        test_debounce_reject();
        test_saturation();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
